wb_traffic_gen: RTL and testbench
=================================

# wb_traffic_gen

Synthesizable Wishbone master traffic generator and checker. It drives the SDRAM controller's Wishbone port with programmable write, read and write-then-verify burst sequences. It replaces the static idle-tie-off stimulus in the emulation-side top with an engine that runs entirely in the clock domain, with no testbench time delays. Results come back as a pass flag, an error count and the first failing address.

## Interface

Parameters:
- DW, 32: Wishbone data width. Legal values are 32, 64 and 128.
- AW, 26: Wishbone byte-address width.
- BL_MAX, 8: maximum beats per burst (power of two, 1..256).
- TO_CYCLES, 1024: number of cycles without an ack before the sequence aborts.

Ports (name, direction, width, meaning):
- sys_clk, in, 1: the single clock.
- RESETN, in, 1: reset, asynchronous and active-low.
- sdr_init_done, in, 1: SDRAM initialisation complete.
- start, in, 1: one-cycle request to run a sequence.
- cfg_mode, in, 2: 00 write-only, 01 read-only, 10 write-then-read-check, 11 reserved.
- cfg_base_addr, in, AW: starting byte address.
- cfg_num_bursts, in, 16: number of bursts per phase.
- cfg_burst_len, in, 9: beats per burst.
- cfg_pattern, in, 1: 0 incrementing, 1 LFSR.
- cfg_seed, in, 32: pattern seed.
- busy, out, 1: sequence running.
- done, out, 1: one-cycle completion pulse.
- pass, out, 1: last sequence finished with zero errors and no timeout.
- timeout, out, 1: last sequence aborted by the watchdog.
- err_cnt, out, 16: read-data mismatch count, saturating.
- first_err_addr, out, AW: address of the first mismatch.
- wb_cyc_o, out, 1
- wb_stb_o, out, 1
- wb_we_o, out, 1
- wb_addr_o, out, AW
- wb_dat_o, out, DW
- wb_sel_o, out, DW/8: all ones whenever stb is high.
- wb_dat_i, in, DW
- wb_ack_i, in, 1

## Operation

- FSM states: IDLE, WAIT_INIT, WR_BURST, WR_GAP, RD_BURST, RD_GAP, FINISH.
- IDLE:
  - start with cfg_mode≠11 latches all cfg_* inputs, clears err_cnt, first_err_addr, pass and timeout, then goes to WAIT_INIT.
  - start with cfg_mode=11 is ignored.
  - start in any other state is ignored.
- WAIT_INIT: wait for sdr_init_done=1. Then go to WR_BURST for modes 00 and 10, or RD_BURST for mode 01.
- Effective burst length: cfg_burst_len=0 or cfg_burst_len>BL_MAX is replaced by BL_MAX.
- cfg_num_bursts=0: go straight to FINISH with pass=1.
- Burst behaviour:
  - cyc and stb stay high for the whole burst.
  - Each ack completes one beat.
  - The address advances by DW/8 per beat and wraps modulo 2^AW.
  - After the last beat, cyc and stb drop for exactly one GAP cycle.
  - The next burst continues at the next address.
- After the last write burst: mode 00 goes to FINISH; mode 10 reloads the address and pattern state from the latched base and seed, then goes to RD_BURST.
- After the last read burst: go to FINISH.
- FINISH: for one cycle, assert done, set pass = (err_cnt==0 && !timeout), then return to IDLE.
- Pattern 0: beat n carries data = cfg_seed + n (32 bits). The value is replicated DW/32 times across the bus.
- Pattern 1:
  - 32-bit Galois LFSR with polynomial 0x80200003, stepped once per beat. The beat's data is the current state, replicated DW/32 times.
  - A seed of 0 is replaced by 0x00000001.
- Read check:
  - On each read ack, compare wb_dat_i with the regenerated expected word.
  - On a mismatch, increment err_cnt, saturating at 0xFFFF.
  - The first mismatch in a sequence captures wb_addr_o into first_err_addr.
  - Mode 01 checks against the pattern as well.

## Timing

- Reset values: all outputs are 0, and the FSM is in IDLE. Reset acts immediately and asynchronously, including in the middle of a burst (cyc and stb drop without waiting for ack).
- busy rises in the cycle after start is sampled and falls in the cycle after done.
- First beat: stb rises in the cycle after leaving WAIT_INIT.
- Beat advance: an ack sampled at a rising edge presents the next address and data in that same edge's output. With zero-wait acks, a burst therefore takes N cycles.
- wb_ack_i is ignored while stb is low.
- Watchdog:
  - The counter resets on every ack and on entry to each burst.
  - If it reaches TO_CYCLES while stb is high: drop cyc/stb, set timeout=1, go to FINISH (pass=0).
  - If the ack and the terminal count occur in the same cycle, the ack wins.
- Write data and sel are stable for as long as stb is held.
- Read data is sampled only in the ack cycle.

## Test plan

- Mode 10, base 0x100, 4 bursts of length 8, pattern 0, seed 0x1000, ideal slave memory:
  - 32 writes to 0x100..0x17C, then 32 reads.
  - err_cnt=0, pass=1, a single done pulse.
- Same setup, with the slave corrupting the read at 0x124:
  - err_cnt=1, first_err_addr=0x124, pass=0.
- cfg_burst_len=0 with BL_MAX=8, and cfg_burst_len=300:
  - In both cases, each burst is 8 beats with a one-cycle cyc gap between bursts.
- Slave that never acks during write beat 3:
  - After 1024 cycles, cyc drops, timeout=1, pass=0, done pulses.
- RESETN asserted in the middle of a read burst:
  - All outputs are 0 immediately.
  - A later start with mode 00 runs cleanly from the base address.
- Pattern 1, seed 0, mode 00:
  - First written word is 0x00000001; the second is the LFSR step of 1.
- start held during WAIT_INIT while sdr_init_done=0 for 500 cycles:
  - No stb is issued and the start is not re-latched.

Source files
------------

// File: rtl/wb_traffic_gen_if.sv
// Wishbone master bundle for the traffic generator.
// Signal names follow the SDRAM controller's port naming.
interface wb_traffic_gen_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_addr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_addr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_traffic_gen.sv
// Wishbone burst traffic generator / read checker for the
// SDRAM controller port: write, read and write-then-verify.
module wb_traffic_gen #(
  parameter int DW        = 32,
  parameter int AW        = 26,
  parameter int BL_MAX    = 8,
  parameter int TO_CYCLES = 1024
) (
  input  logic          sys_clk,
  input  logic          RESETN,
  input  logic          sdr_init_done,
  input  logic          start,
  input  logic [1:0]    cfg_mode,
  input  logic [AW-1:0] cfg_base_addr,
  input  logic [15:0]   cfg_num_bursts,
  input  logic [8:0]    cfg_burst_len,
  input  logic          cfg_pattern,
  input  logic [31:0]   cfg_seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  wb_traffic_gen_if.master wb
);

  localparam int WW = $clog2(TO_CYCLES + 1);
  localparam logic [8:0] BLM = 9'(BL_MAX);
  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  typedef enum logic [2:0] {
    IDLE, WAIT_INIT, WR_BURST, WR_GAP,
    RD_BURST, RD_GAP, FINISH
  } state_t;

  state_t        state;
  logic [1:0]    mode_l;
  logic [AW-1:0] base_l;
  logic [15:0]   nb_l;
  logic [8:0]    bl_l;
  logic          pat_l;
  logic [31:0]   seed_l;
  logic [AW-1:0] addr;
  logic [31:0]   pat_st;
  logic [8:0]    beat;
  logic [15:0]   burst;
  logic [WW-1:0] wdog;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [DW-1:0] dat_w;

  // pat_st always holds the word of the beat currently presented
  function automatic logic [31:0] pat_next(
    input logic [31:0] s,
    input logic        p
  );
    if (p)
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    return s + 32'd1;
  endfunction

  assign dat_w        = {(DW/32){pat_st}};
  assign wb.wb_cyc_o  = cyc;
  assign wb.wb_stb_o  = stb;
  assign wb.wb_we_o   = we;
  assign wb.wb_addr_o = addr;
  assign wb.wb_dat_o  = dat_w;
  assign wb.wb_sel_o  = {(DW/8){stb}};

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state          <= IDLE;
      mode_l         <= '0;
      base_l         <= '0;
      nb_l           <= '0;
      bl_l           <= '0;
      pat_l          <= 1'b0;
      seed_l         <= '0;
      addr           <= '0;
      pat_st         <= '0;
      beat           <= '0;
      burst          <= '0;
      wdog           <= '0;
      cyc            <= 1'b0;
      stb            <= 1'b0;
      we             <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && cfg_mode != 2'b11) begin
            mode_l  <= cfg_mode;
            base_l  <= cfg_base_addr;
            nb_l    <= cfg_num_bursts;
            bl_l    <= (cfg_burst_len == 9'd0 ||
                        cfg_burst_len > BLM) ?
                       BLM : cfg_burst_len;
            pat_l   <= cfg_pattern;
            seed_l  <= (cfg_pattern && cfg_seed == 32'd0) ?
                       32'd1 : cfg_seed;
            busy           <= 1'b1;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            state          <= WAIT_INIT;
          end
        end
        WAIT_INIT: begin
          if (nb_l == 16'd0) begin
            done  <= 1'b1;
            pass  <= 1'b1;
            state <= FINISH;
          end else if (sdr_init_done) begin
            addr   <= base_l;
            pat_st <= seed_l;
            beat   <= '0;
            burst  <= '0;
            wdog   <= '0;
            cyc    <= 1'b1;
            stb    <= 1'b1;
            we     <= (mode_l != 2'b01);
            state  <= (mode_l == 2'b01) ? RD_BURST : WR_BURST;
          end
        end
        WR_BURST, RD_BURST: begin
          if (wb.wb_ack_i) begin
            wdog   <= '0;
            addr   <= addr + STEP;
            pat_st <= pat_next(pat_st, pat_l);
            if (state == RD_BURST && wb.wb_dat_i != dat_w) begin
              if (err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
              if (err_cnt == 16'd0)
                first_err_addr <= addr;
            end
            if (beat == bl_l - 9'd1) begin
              beat  <= '0;
              burst <= burst + 16'd1;
              cyc   <= 1'b0;
              stb   <= 1'b0;
              state <= (state == WR_BURST) ? WR_GAP : RD_GAP;
            end else begin
              beat <= beat + 9'd1;
            end
          end else if (wdog == WW'(TO_CYCLES - 1)) begin
            cyc     <= 1'b0;
            stb     <= 1'b0;
            timeout <= 1'b1;
            pass    <= 1'b0;
            done    <= 1'b1;
            state   <= FINISH;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        WR_GAP: begin
          wdog <= '0;
          if (burst != nb_l) begin
            cyc   <= 1'b1;
            stb   <= 1'b1;
            state <= WR_BURST;
          end else if (mode_l == 2'b10) begin
            // verify pass replays the same address/pattern stream
            addr   <= base_l;
            pat_st <= seed_l;
            burst  <= '0;
            cyc    <= 1'b1;
            stb    <= 1'b1;
            we     <= 1'b0;
            state  <= RD_BURST;
          end else begin
            done  <= 1'b1;
            pass  <= (err_cnt == 16'd0);
            state <= FINISH;
          end
        end
        RD_GAP: begin
          wdog <= '0;
          if (burst != nb_l) begin
            cyc   <= 1'b1;
            stb   <= 1'b1;
            state <= RD_BURST;
          end else begin
            done  <= 1'b1;
            pass  <= (err_cnt == 16'd0);
            state <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          we    <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Bench for wb_traffic_gen: memory slave with random waits,
// reference model of the address/pattern stream and checker.
module tb_wb_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [25:0] cfg_base_addr = '0;
  logic [15:0] cfg_num_bursts = '0;
  logic [8:0]  cfg_burst_len = '0;
  logic        cfg_pattern = 1'b0;
  logic [31:0] cfg_seed = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [25:0] first_err_addr;

  int total = 0;
  int bad = 0;

  wb_traffic_gen_if #(.DW(32), .AW(26)) wb ();

  wb_traffic_gen #(
    .DW(32), .AW(26), .BL_MAX(8), .TO_CYCLES(1024)
  ) dut (
    .sys_clk        (clk),
    .RESETN         (rst_n),
    .sdr_init_done  (init_done),
    .start          (start),
    .cfg_mode       (cfg_mode),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_bursts (cfg_num_bursts),
    .cfg_burst_len  (cfg_burst_len),
    .cfg_pattern    (cfg_pattern),
    .cfg_seed       (cfg_seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .wb             (wb)
  );

  always #5 clk = ~clk;

  // slave behaviour knobs
  int          wait_pct = 0;
  bit          noise = 1'b0;
  bit          corrupt_en = 1'b0;
  logic [25:0] corrupt_addr = '0;
  int          stall_idx = -1;
  logic [31:0] pre_mem [logic [25:0]];

  // monitor state
  int          clr_req = 0;
  int          clr_ack = 0;
  bit          tq_we [$];
  logic [25:0] tq_addr [$];
  logic [31:0] tq_dat [$];
  int          bursts [$];
  int          gaps [$];
  int          done_cnt, wr_acks, stb_seen, sel_bad;
  int          max_run, run, beats, gap;
  bit          prev_cyc, seen;
  logic [31:0] mem [logic [25:0]];

  // model output
  bit          ex_we [$];
  logic [25:0] ex_addr [$];
  logic [31:0] ex_dat [$];
  int          ex_err;
  logic [25:0] ex_first;

  always @(posedge clk) begin
    logic [31:0] d;
    bit stall;
    #1;
    if (wb.wb_stb_o) begin
      stall = stall_idx >= 0 && wb.wb_we_o &&
              wr_acks == stall_idx;
      wb.wb_ack_i = !stall &&
                    (int'($urandom_range(99)) >= wait_pct);
    end else begin
      wb.wb_ack_i = noise && ($urandom_range(3) == 0);
    end
    if (mem.exists(wb.wb_addr_o)) d = mem[wb.wb_addr_o];
    else if (pre_mem.exists(wb.wb_addr_o))
      d = pre_mem[wb.wb_addr_o];
    else d = 32'hDEAD_BEEF;
    if (corrupt_en && wb.wb_addr_o == corrupt_addr)
      d = d ^ 32'h1;
    wb.wb_dat_i = d;
  end

  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      tq_we.delete(); tq_addr.delete(); tq_dat.delete();
      bursts.delete(); gaps.delete(); mem.delete();
      done_cnt = 0; wr_acks = 0; stb_seen = 0; sel_bad = 0;
      max_run = 0; run = 0; beats = 0; gap = 0;
      prev_cyc = 1'b0; seen = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (wb.wb_stb_o) begin
        stb_seen++;
        if (wb.wb_sel_o !== 4'hF) sel_bad++;
      end
      if (wb.wb_stb_o && wb.wb_ack_i) begin
        tq_we.push_back(wb.wb_we_o);
        tq_addr.push_back(wb.wb_addr_o);
        tq_dat.push_back(wb.wb_we_o ? wb.wb_dat_o : 32'h0);
        if (wb.wb_we_o) begin
          mem[wb.wb_addr_o] = wb.wb_dat_o;
          wr_acks++;
        end
        beats++;
        run = 0;
      end else if (wb.wb_stb_o) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (wb.wb_cyc_o) begin
        if (!prev_cyc && seen) gaps.push_back(gap);
        gap = 0;
      end else begin
        if (prev_cyc) begin
          bursts.push_back(beats);
          beats = 0;
          seen = 1'b1;
        end
        gap++;
      end
      prev_cyc = wb.wb_cyc_o;
    end
  end

  function automatic logic [31:0] pat_word(
    input bit p, input logic [31:0] s, input int n
  );
    logic [31:0] v;
    if (!p) return s + 32'(n);
    v = (s == 32'd0) ? 32'd1 : s;
    for (int k = 0; k < n; k++)
      v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    return v;
  endfunction

  // expected transaction stream and error result
  task automatic build_model(
    input logic [1:0] m, input logic [25:0] b,
    input int nb, input int bl,
    input bit p, input logic [31:0] s
  );
    int ebl;
    logic [25:0] a;
    logic [31:0] e, r;
    ebl = (bl == 0 || bl > 8) ? 8 : bl;
    ex_we.delete(); ex_addr.delete(); ex_dat.delete();
    ex_err = 0;
    ex_first = '0;
    if (m != 2'd1)
      for (int i = 0; i < nb * ebl; i++) begin
        ex_we.push_back(1'b1);
        ex_addr.push_back(b + 26'(4 * i));
        ex_dat.push_back(pat_word(p, s, i));
      end
    if (m != 2'd0)
      for (int i = 0; i < nb * ebl; i++) begin
        a = b + 26'(4 * i);
        e = pat_word(p, s, i);
        if (m == 2'd2) r = e;
        else if (pre_mem.exists(a)) r = pre_mem[a];
        else r = 32'hDEAD_BEEF;
        if (corrupt_en && a == corrupt_addr) r = r ^ 32'h1;
        ex_we.push_back(1'b0);
        ex_addr.push_back(a);
        ex_dat.push_back(32'h0);
        if (r != e) begin
          if (ex_err == 0) ex_first = a;
          ex_err++;
        end
      end
  endtask

  task automatic run_seq(
    input logic [1:0] m, input logic [25:0] b,
    input int nb, input int bl,
    input bit p, input logic [31:0] s,
    input int budget, output bit ok
  );
    clr_req++;
    @(negedge clk);
    cfg_mode = m;
    cfg_base_addr = b;
    cfg_num_bursts = 16'(nb);
    cfg_burst_len = 9'(bl);
    cfg_pattern = p;
    cfg_seed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, pass, timeout, err_cnt, first_err_addr}
        !== '0) begin
      bad++;
      $display("FAIL reset_status: got %0h want 0",
        {busy, done, pass, timeout, err_cnt, first_err_addr});
    end
    total++;
    if ({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_addr_o,
         wb.wb_dat_o, wb.wb_sel_o} !== '0) begin
      bad++;
      $display("FAIL reset_bus: addr %0h dat %0h",
        wb.wb_addr_o, wb.wb_dat_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy: got %0b want 0", busy);
    end
  endtask

  task automatic test_wr_rd_check;
    bit ok;
    build_model(2'd2, 26'h100, 4, 8, 1'b0, 32'h1000);
    run_seq(2'd2, 26'h100, 4, 8, 1'b0, 32'h1000, 500, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL wrrd_done: got %0b want 1", ok);
    end
    total++;
    if (tq_addr.size() !== ex_addr.size()) begin
      bad++;
      $display("FAIL wrrd_count: got %0d want %0d",
        tq_addr.size(), ex_addr.size());
    end
    for (int i = 0; i < tq_addr.size() && i < ex_addr.size(); i++) begin
      total++;
      if ({tq_we[i], tq_addr[i], tq_dat[i]} !==
          {ex_we[i], ex_addr[i], ex_dat[i]}) begin
        bad++;
        $display("FAIL wrrd_txn%0d: got %0b/%0h/%0h want %0b/%0h/%0h",
          i, tq_we[i], tq_addr[i], tq_dat[i],
          ex_we[i], ex_addr[i], ex_dat[i]);
      end
    end
    total++;
    if ({err_cnt, pass, timeout} !== {16'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL wrrd_result: err %0d pass %0b to %0b want 0/1/0",
        err_cnt, pass, timeout);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL wrrd_done_cnt: got %0d want 1", done_cnt);
    end
    total++;
    if (sel_bad !== 0) begin
      bad++;
      $display("FAIL wrrd_sel: got %0d bad beats want 0", sel_bad);
    end
    total++;
    if (bursts.size() !== 8 || gaps.size() !== 7) begin
      bad++;
      $display("FAIL wrrd_shape: bursts %0d gaps %0d want 8/7",
        bursts.size(), gaps.size());
    end
    foreach (gaps[i]) begin
      total++;
      if (gaps[i] !== 1) begin
        bad++;
        $display("FAIL wrrd_gap%0d: got %0d want 1", i, gaps[i]);
      end
    end
  endtask

  task automatic test_corrupt;
    bit ok;
    corrupt_en = 1'b1;
    corrupt_addr = 26'h124;
    build_model(2'd2, 26'h100, 4, 8, 1'b0, 32'h1000);
    run_seq(2'd2, 26'h100, 4, 8, 1'b0, 32'h1000, 500, ok);
    corrupt_en = 1'b0;
    total++;
    if (ok !== 1'b1 || ex_err !== 1) begin
      bad++;
      $display("FAIL corrupt_done: got %0b/%0d want 1/1", ok, ex_err);
    end
    total++;
    if (err_cnt !== 16'd1) begin
      bad++;
      $display("FAIL corrupt_err_cnt: got %0d want 1", err_cnt);
    end
    total++;
    if (first_err_addr !== 26'h124) begin
      bad++;
      $display("FAIL corrupt_addr: got %0h want 124", first_err_addr);
    end
    total++;
    if (pass !== 1'b0) begin
      bad++;
      $display("FAIL corrupt_pass: got %0b want 0", pass);
    end
  endtask

  task automatic test_burst_clamp;
    bit ok;
    int lens [2] = '{0, 300};
    foreach (lens[k]) begin
      run_seq(2'd0, 26'h2000, 3, lens[k], 1'b0, 32'h7, 500, ok);
      total++;
      if (ok !== 1'b1 || bursts.size() !== 3 ||
          gaps.size() !== 2) begin
        bad++;
        $display("FAIL clamp%0d_shape: ok %0b bursts %0d gaps %0d",
          lens[k], ok, bursts.size(), gaps.size());
      end
      foreach (bursts[i]) begin
        total++;
        if (bursts[i] !== 8) begin
          bad++;
          $display("FAIL clamp%0d_len: got %0d want 8",
            lens[k], bursts[i]);
        end
      end
      foreach (gaps[i]) begin
        total++;
        if (gaps[i] !== 1) begin
          bad++;
          $display("FAIL clamp%0d_gap: got %0d want 1",
            lens[k], gaps[i]);
        end
      end
    end
  endtask

  task automatic test_lfsr_seed0;
    bit ok;
    run_seq(2'd0, 26'h40, 1, 2, 1'b1, 32'h0, 200, ok);
    total++;
    if (ok !== 1'b1 || tq_dat.size() !== 2) begin
      bad++;
      $display("FAIL lfsr_count: ok %0b got %0d want 2",
        ok, tq_dat.size());
    end else begin
      total++;
      if (tq_dat[0] !== 32'h0000_0001) begin
        bad++;
        $display("FAIL lfsr_w0: got %0h want 1", tq_dat[0]);
      end
      total++;
      if (tq_dat[1] !== 32'h8020_0003) begin
        bad++;
        $display("FAIL lfsr_w1: got %0h want 80200003", tq_dat[1]);
      end
    end
  endtask

  task automatic test_zero_bursts;
    bit ok;
    run_seq(2'd2, 26'h80, 0, 4, 1'b0, 32'h0, 50, ok);
    total++;
    if ({ok, pass, done_cnt == 1, stb_seen == 0} !== 4'hF) begin
      bad++;
      $display("FAIL zero_bursts: ok %0b pass %0b done %0d stb %0d",
        ok, pass, done_cnt, stb_seen);
    end
  endtask

  task automatic test_mode_reserved;
    clr_req++;
    @(negedge clk);
    cfg_mode = 2'b11;
    cfg_num_bursts = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b0 || stb_seen !== 0 || done_cnt !== 0) begin
      bad++;
      $display("FAIL mode11: busy %0b stb %0d done %0d want 0",
        busy, stb_seen, done_cnt);
    end
  endtask

  task automatic test_start_hold;
    bit ok;
    build_model(2'd0, 26'h40, 1, 4, 1'b0, 32'h5);
    clr_req++;
    @(negedge clk);
    init_done = 1'b0;
    cfg_mode = 2'b00;
    cfg_base_addr = 26'h40;
    cfg_num_bursts = 16'd1;
    cfg_burst_len = 9'd4;
    cfg_pattern = 1'b0;
    cfg_seed = 32'h5;
    start = 1'b1;
    @(negedge clk);
    cfg_base_addr = 26'h800;
    cfg_seed = 32'h9;
    repeat (500) @(negedge clk);
    total++;
    if (stb_seen !== 0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL hold_wait: stb %0d busy %0b want 0/1",
        stb_seen, busy);
    end
    start = 1'b0;
    init_done = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (ok !== 1'b1 || tq_addr.size() !== ex_addr.size()) begin
      bad++;
      $display("FAIL hold_count: ok %0b got %0d want %0d",
        ok, tq_addr.size(), ex_addr.size());
    end
    for (int i = 0; i < tq_addr.size() && i < ex_addr.size(); i++) begin
      total++;
      if ({tq_addr[i], tq_dat[i]} !== {ex_addr[i], ex_dat[i]}) begin
        bad++;
        $display("FAIL hold_txn%0d: got %0h/%0h want %0h/%0h",
          i, tq_addr[i], tq_dat[i], ex_addr[i], ex_dat[i]);
      end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    stall_idx = 3;
    run_seq(2'd0, 26'h300, 2, 8, 1'b0, 32'h0, 1500, ok);
    stall_idx = -1;
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL to_done: got %0b want 1", ok);
    end
    total++;
    if (max_run !== 1024) begin
      bad++;
      $display("FAIL to_cycles: got %0d want 1024", max_run);
    end
    total++;
    if ({timeout, pass, wb.wb_cyc_o} !== 3'b100) begin
      bad++;
      $display("FAIL to_flags: got %b want 100",
        {timeout, pass, wb.wb_cyc_o});
    end
    total++;
    if (tq_addr.size() !== 3 || done_cnt !== 1) begin
      bad++;
      $display("FAIL to_beats: got %0d/%0d want 3/1",
        tq_addr.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    bit ok, hit;
    clr_req++;
    @(negedge clk);
    wait_pct = 30;
    cfg_mode = 2'b10;
    cfg_base_addr = 26'h600;
    cfg_num_bursts = 16'd4;
    cfg_burst_len = 9'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 600 && !hit; c++) begin
      @(negedge clk);
      hit = wb.wb_stb_o && !wb.wb_we_o;
    end
    repeat ($urandom_range(3)) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (hit !== 1'b1 ||
        {busy, done, pass, timeout, err_cnt, first_err_addr,
         wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_addr_o,
         wb.wb_dat_o, wb.wb_sel_o} !== '0) begin
      bad++;
      $display("FAIL midreset: hit %0b cyc %0b stb %0b addr %0h",
        hit, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_addr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    build_model(2'd0, 26'h200, 2, 4, 1'b1, 32'h1234_5678);
    run_seq(2'd0, 26'h200, 2, 4, 1'b1, 32'h1234_5678, 500, ok);
    wait_pct = 0;
    total++;
    if (ok !== 1'b1 || pass !== 1'b1 ||
        tq_addr.size() !== ex_addr.size()) begin
      bad++;
      $display("FAIL postreset: ok %0b pass %0b n %0d want %0d",
        ok, pass, tq_addr.size(), ex_addr.size());
    end
    for (int i = 0; i < tq_addr.size() && i < ex_addr.size(); i++) begin
      total++;
      if ({tq_addr[i], tq_dat[i]} !== {ex_addr[i], ex_dat[i]}) begin
        bad++;
        $display("FAIL postreset_txn%0d: got %0h/%0h want %0h/%0h",
          i, tq_addr[i], tq_dat[i], ex_addr[i], ex_dat[i]);
      end
    end
  endtask

  task automatic test_random;
    bit ok, p;
    logic [1:0] m;
    logic [25:0] b;
    logic [31:0] s;
    int nb, bl, ebl;
    for (int it = 0; it < 8; it++) begin
      m = 2'($urandom_range(2));
      b = 26'($urandom) & 26'h3FF_FFFC;
      if (it % 3 == 0) b = 26'h3FF_FFF0;
      nb = $urandom_range(1, 4);
      bl = $urandom_range(0, 10);
      ebl = (bl == 0 || bl > 8) ? 8 : bl;
      p = 1'($urandom_range(1));
      s = (it == 1) ? 32'h0 : $urandom;
      wait_pct = $urandom_range(40);
      noise = 1'b1;
      pre_mem.delete();
      for (int i = 0; i < nb * ebl; i++)
        pre_mem[b + 26'(4 * i)] = ($urandom_range(9) < 7) ?
          pat_word(p, s, i) : $urandom;
      corrupt_en = 1'($urandom_range(1));
      corrupt_addr = b + 26'(4 * $urandom_range(nb * ebl - 1));
      build_model(m, b, nb, bl, p, s);
      run_seq(m, b, nb, bl, p, s, 2000, ok);
      total++;
      if (ok !== 1'b1 || tq_addr.size() !== ex_addr.size()) begin
        bad++;
        $display("FAIL rnd%0d_count: ok %0b got %0d want %0d",
          it, ok, tq_addr.size(), ex_addr.size());
      end
      for (int i = 0; i < tq_addr.size() && i < ex_addr.size(); i++) begin
        total++;
        if ({tq_we[i], tq_addr[i], tq_dat[i]} !==
            {ex_we[i], ex_addr[i], ex_dat[i]}) begin
          bad++;
          $display("FAIL rnd%0d_txn%0d: got %0h/%0h want %0h/%0h",
            it, i, tq_addr[i], tq_dat[i], ex_addr[i], ex_dat[i]);
        end
      end
      total++;
      if ({err_cnt, first_err_addr, pass} !==
          {16'(ex_err), ex_first, ex_err == 0}) begin
        bad++;
        $display("FAIL rnd%0d_result: err %0d@%0h pass %0b want %0d@%0h",
          it, err_cnt, first_err_addr, pass, ex_err, ex_first);
      end
      total++;
      if (done_cnt !== 1 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_done: done %0d to %0b want 1/0",
          it, done_cnt, timeout);
      end
    end
    noise = 1'b0;
    wait_pct = 0;
    corrupt_en = 1'b0;
    pre_mem.delete();
  endtask

  initial begin
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = '0;
    test_reset;
    test_wr_rd_check;
    test_corrupt;
    test_burst_clamp;
    test_lfsr_seed0;
    test_zero_bursts;
    test_mode_reserved;
    test_start_hold;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
